// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port register file: address width,
// controller states and the default data width.
package regfile_mp_pkg;

    localparam int REG_ADDR_W   = 5;
    localparam int XLEN_DEFAULT = 32;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_mp_rdport.sv
// One combinational read port: x0/range check, clear blanking and the
// optional same-cycle forwarding from the two write ports.
module regfile_rdport
    import regfile_mp_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int NREGS  = 32,
    parameter int BYPASS = 1
) (
    input  logic [REG_ADDR_W-1:0]       addr,
    input  logic [NREGS-1:1][XLEN-1:0]  regs,
    input  logic                        ready,
    input  logic                        we0,
    input  logic [REG_ADDR_W-1:0]       a3,
    input  logic [XLEN-1:0]             wd3,
    input  logic                        we1,
    input  logic [REG_ADDR_W-1:0]       a4,
    input  logic [XLEN-1:0]             wd4,
    output logic [XLEN-1:0]             rd
);

    localparam logic [REG_ADDR_W:0] NREGS_W = (REG_ADDR_W + 1)'(NREGS);

    logic [XLEN-1:0] stored;
    logic            valid;

    always_comb begin
        stored = '0;
        for (int i = 1; i < NREGS; i++) begin
            if (addr == REG_ADDR_W'(i)) begin
                stored = regs[i];
            end
        end
    end

    assign valid = ready && (addr != '0) && ({1'b0, addr} < NREGS_W);

    // we0/we1 arrive already qualified, so port 0 priority here matches the
    // collision rule applied to storage.
    always_comb begin
        rd = '0;
        if (valid) begin
            if ((BYPASS != 0) && we0 && (a3 == addr)) begin
                rd = wd3;
            end else if ((BYPASS != 0) && we1 && (a4 == addr)) begin
                rd = wd4;
            end else begin
                rd = stored;
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Register file with two read and two write ports, x0 hard-wired to zero and
// a sequential clear controller that re-zeroes the file after reset or on request.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int NREGS  = 32,
    parameter int BYPASS = 1
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic                  clr_req,
    input  logic [REG_ADDR_W-1:0] A1,
    input  logic [REG_ADDR_W-1:0] A2,
    output logic [XLEN-1:0]       RD1,
    output logic [XLEN-1:0]       RD2,
    input  logic [REG_ADDR_W-1:0] A3,
    input  logic                  WE3,
    input  logic [XLEN-1:0]       WD3,
    input  logic [REG_ADDR_W-1:0] A4,
    input  logic                  WE4,
    input  logic [XLEN-1:0]       WD4,
    output logic                  busy
);

    localparam logic [REG_ADDR_W:0]   NREGS_W  = (REG_ADDR_W + 1)'(NREGS);
    localparam logic [REG_ADDR_W-1:0] LAST_IDX = REG_ADDR_W'(NREGS - 1);

    logic [NREGS-1:1][XLEN-1:0] regs;
    state_t                     state;
    logic [REG_ADDR_W-1:0]      idx;
    logic                       ready;
    logic                       we0;
    logic                       we1;

    assign ready = (state == READY);
    assign we0   = WE3 && ready && (A3 != '0) && ({1'b0, A3} < NREGS_W);
    assign we1   = WE4 && ready && (A4 != '0) && ({1'b0, A4} < NREGS_W)
                   && !(we0 && (A4 == A3));

    always_ff @(posedge CLK) begin
        if (reset) begin
            state <= CLEAR;
            idx   <= REG_ADDR_W'(1);
            busy  <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    if (idx == LAST_IDX) begin
                        state <= READY;
                        busy  <= 1'b0;
                    end else begin
                        idx <= idx + REG_ADDR_W'(1);
                    end
                end
                READY: begin
                    if (clr_req) begin
                        state <= CLEAR;
                        idx   <= REG_ADDR_W'(1);
                        busy  <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Storage carries no reset; contents are defined only by the clear walk.
    always_ff @(posedge CLK) begin
        for (int i = 1; i < NREGS; i++) begin
            if (!reset) begin
                if (!ready) begin
                    if (idx == REG_ADDR_W'(i)) begin
                        regs[i] <= '0;
                    end
                end else if (we0 && (A3 == REG_ADDR_W'(i))) begin
                    regs[i] <= WD3;
                end else if (we1 && (A4 == REG_ADDR_W'(i))) begin
                    regs[i] <= WD4;
                end
            end
        end
    end

    regfile_rdport #(
        .XLEN   (XLEN),
        .NREGS  (NREGS),
        .BYPASS (BYPASS)
    ) u_rd1 (
        .addr  (A1),
        .regs  (regs),
        .ready (ready),
        .we0   (we0),
        .a3    (A3),
        .wd3   (WD3),
        .we1   (we1),
        .a4    (A4),
        .wd4   (WD4),
        .rd    (RD1)
    );

    regfile_rdport #(
        .XLEN   (XLEN),
        .NREGS  (NREGS),
        .BYPASS (BYPASS)
    ) u_rd2 (
        .addr  (A2),
        .regs  (regs),
        .ready (ready),
        .we0   (we0),
        .a3    (A3),
        .wd3   (WD3),
        .we1   (we1),
        .a4    (A4),
        .wd4   (WD4),
        .rd    (RD2)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: three configurations share one stimulus stream and are
// compared every cycle against an array-based model of the register file.
module tb_regfile_mp;

    logic        CLK = 1'b0;
    logic        reset, clr_req;
    logic [4:0]  A1, A2, A3, A4;
    logic        WE3, WE4;
    logic [31:0] WD3, WD4;

    logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b, rd1_c, rd2_c;
    logic        busy_a, busy_b, busy_c;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    always #5 CLK = ~CLK;

    regfile_mp #(.XLEN(32), .NREGS(32), .BYPASS(1)) u_a (
        .CLK(CLK), .reset(reset), .clr_req(clr_req), .A1(A1), .A2(A2),
        .RD1(rd1_a), .RD2(rd2_a), .A3(A3), .WE3(WE3), .WD3(WD3),
        .A4(A4), .WE4(WE4), .WD4(WD4), .busy(busy_a));

    regfile_mp #(.XLEN(32), .NREGS(16), .BYPASS(1)) u_b (
        .CLK(CLK), .reset(reset), .clr_req(clr_req), .A1(A1), .A2(A2),
        .RD1(rd1_b), .RD2(rd2_b), .A3(A3), .WE3(WE3), .WD3(WD3),
        .A4(A4), .WE4(WE4), .WD4(WD4), .busy(busy_b));

    regfile_mp #(.XLEN(32), .NREGS(32), .BYPASS(0)) u_c (
        .CLK(CLK), .reset(reset), .clr_req(clr_req), .A1(A1), .A2(A2),
        .RD1(rd1_c), .RD2(rd2_c), .A3(A3), .WE3(WE3), .WD3(WD3),
        .A4(A4), .WE4(WE4), .WD4(WD4), .busy(busy_c));

    // Model: per configuration, register contents plus remaining busy cycles.
    int          nr[3] = '{32, 16, 32};
    bit          bp[3] = '{1'b1, 1'b1, 1'b0};
    int          left[3];
    logic [31:0] mr[3][32];

    function automatic bit qual(int k, logic we, logic [4:0] a);
        return we && (left[k] == 0) && (a != 0) && (int'(a) < nr[k]);
    endfunction

    function automatic logic [31:0] mread(int k, logic [4:0] a);
        if (left[k] > 0 || a == 0 || int'(a) >= nr[k]) return 32'h0;
        if (bp[k] && qual(k, WE3, A3) && A3 == a) return WD3;
        if (bp[k] && qual(k, WE4, A4) && A4 == a) return WD4;
        return mr[k][a];
    endfunction

    always @(posedge CLK) begin
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                left[k] <= nr[k] - 1;
                for (int r = 0; r < 32; r++) mr[k][r] <= 32'h0;
            end else if (left[k] > 0) begin
                left[k] <= left[k] - 1;
            end else begin
                if (qual(k, WE4, A4)) mr[k][A4] <= WD4;
                if (qual(k, WE3, A3)) mr[k][A3] <= WD3;
                if (clr_req) begin
                    left[k] <= nr[k] - 1;
                    for (int r = 0; r < 32; r++) mr[k][r] <= 32'h0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            check("a_busy", 32'(busy_a), 32'(left[0] > 0));
            check("b_busy", 32'(busy_b), 32'(left[1] > 0));
            check("c_busy", 32'(busy_c), 32'(left[2] > 0));
            check("a_rd1", rd1_a, mread(0, A1));
            check("a_rd2", rd2_a, mread(0, A2));
            check("b_rd1", rd1_b, mread(1, A1));
            check("b_rd2", rd2_b, mread(1, A2));
            check("c_rd1", rd1_c, mread(2, A1));
            check("c_rd2", rd2_c, mread(2, A2));
        end
    end

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        WE3 = 0; WE4 = 0; clr_req = 0; reset = 0;
    endtask

    task automatic count_busy(input int wr_at, output int ca, output int cb);
        ca = 0; cb = 0;
        for (int i = 0; i < 40; i++) begin
            if (i == wr_at) begin
                WE4 = 1; A4 = 5'd3; WD4 = 32'h99;
            end else begin
                WE4 = 0;
            end
            @(negedge CLK);
            if (busy_a) ca++;
            if (busy_b) cb++;
            next_cycle();
        end
        WE4 = 0;
    endtask

    int ca, cb;

    initial begin
        idle();
        A1 = 0; A2 = 0; A3 = 0; A4 = 0; WD3 = 0; WD4 = 0;
        reset = 1;
        next_cycle();
        chk_en = 1;
        reset  = 0;
        count_busy(-1, ca, cb);
        check("reset_busy_cycles_32", ca, 31);
        check("reset_busy_cycles_16", cb, 15);
        A1 = 5'd5;
        @(negedge CLK);
        check("after_reset_x5", rd1_a, 32'h0);

        // Same-cycle forwarding vs. registered-only read.
        next_cycle();
        WE3 = 1; A3 = 5'd7; WD3 = 32'hDEADBEEF; A1 = 5'd7;
        @(negedge CLK);
        check("bypass_same_cycle", rd1_a, 32'hDEADBEEF);
        check("model_bypass", mread(0, 5'd7), 32'hDEADBEEF);
        check("nobypass_same_cycle", rd1_c, 32'h0);
        next_cycle();
        WE3 = 0;
        @(negedge CLK);
        check("bypass_next_cycle", rd1_a, 32'hDEADBEEF);
        check("nobypass_next_cycle", rd1_c, 32'hDEADBEEF);

        // Write collision: port 0 wins.
        next_cycle();
        WE3 = 1; WE4 = 1; A3 = 5'd9; A4 = 5'd9; WD3 = 32'h11; WD4 = 32'h22;
        next_cycle();
        WE3 = 0; WE4 = 0; A1 = 5'd9;
        @(negedge CLK);
        check("collision_a", rd1_a, 32'h11);
        check("collision_c", rd1_c, 32'h11);
        check("model_collision", mread(0, 5'd9), 32'h11);

        // x0 and out-of-range on the 16-entry file.
        next_cycle();
        WE3 = 1; A3 = 5'd0; WD3 = 32'h55; A1 = 5'd0;
        @(negedge CLK);
        check("x0_fwd", rd1_b, 32'h0);
        next_cycle();
        A3 = 5'd20; A1 = 5'd20;
        @(negedge CLK);
        check("range_fwd_b", rd1_b, 32'h0);
        check("in_range_fwd_a", rd1_a, 32'h55);
        next_cycle();
        WE3 = 0; A1 = 5'd20; A2 = 5'd4;
        @(negedge CLK);
        check("range_read_b", rd1_b, 32'h0);
        check("alias_x4_b", rd2_b, 32'h0);
        next_cycle();
        A1 = 5'd0;
        @(negedge CLK);
        check("x0_read_b", rd1_b, 32'h0);

        // Registered-only read on the BYPASS=0 instance.
        next_cycle();
        WE3 = 1; A3 = 5'd4; WD3 = 32'h77; A2 = 5'd4;
        @(negedge CLK);
        check("nobypass_old", rd2_c, 32'h0);
        next_cycle();
        WE3 = 0;
        @(negedge CLK);
        check("nobypass_new", rd2_c, 32'h77);

        // Clear request with an ignored write during busy.
        next_cycle();
        WE3 = 1; A3 = 5'd3; WD3 = 32'hAB;
        next_cycle();
        WE3 = 0; A1 = 5'd3;
        @(negedge CLK);
        check("x3_before_clear", rd1_a, 32'hAB);
        next_cycle();
        clr_req = 1;
        next_cycle();
        clr_req = 0;
        count_busy(3, ca, cb);
        check("clear_busy_cycles_32", ca, 31);
        check("clear_busy_cycles_16", cb, 15);
        A1 = 5'd3;
        @(negedge CLK);
        check("x3_after_clear", rd1_a, 32'h0);

        // Reset in the middle of a clear restarts the walk.
        next_cycle();
        clr_req = 1;
        next_cycle();
        clr_req = 0;
        for (int i = 0; i < 5; i++) next_cycle();
        reset = 1;
        next_cycle();
        reset = 0;
        count_busy(-1, ca, cb);
        check("midclear_reset_busy_32", ca, 31);
        check("midclear_reset_busy_16", cb, 15);

        // Randomized traffic with small address pools to provoke hits.
        for (int n = 0; n < 3000; n++) begin
            A1 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 6));
            A2 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 6));
            A3 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 6));
            A4 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 6));
            WE3 = 1'($urandom_range(0, 1));
            WE4 = 1'($urandom_range(0, 1));
            WD3 = $urandom;
            WD4 = $urandom;
            clr_req = ($urandom_range(0, 99) == 0);
            reset   = ($urandom_range(0, 499) == 0);
            next_cycle();
        end
        idle();
        @(negedge CLK);
        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter XLEN, default 32: data width of every register and data port.
REQ-002 Parameter NREGS, default 32, legal values 2..32: number of architectural registers, x0..x(NREGS-1).
REQ-003 Parameter BYPASS, default 1: when 1, same-cycle write-to-read forwarding is enabled; when 0, it is disabled.
REQ-004 Port CLK, input, 1: the single clock; all state changes occur on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port clr_req, input, 1: request to re-zero the whole file, accepted only in READY.
REQ-007 Ports A1 and A2, input, 5 each: read addresses rs1 and rs2.
REQ-008 Ports RD1 and RD2, output, XLEN each: read data for A1 and A2.
REQ-009 Ports A3, WE3 and WD3, input, 5/1/XLEN: write port 0 (ALU writeback) address, enable and data.
REQ-010 Ports A4, WE4 and WD4, input, 5/1/XLEN: write port 1 (load writeback) address, enable and data.
REQ-011 Port busy, output, 1: high while the clear sequence runs.

Function
REQ-012 The controller SHALL have two states: CLEAR and READY.
REQ-013 In CLEAR, a 5-bit index SHALL start at 1, zero one entry per cycle, and step to READY in the cycle after index NREGS-1 is written.
REQ-014 In CLEAR, busy=1, both write ports are ignored, and RD1=RD2=0.
REQ-015 In READY, busy=0.
REQ-016 clr_req=1 in READY SHALL move the controller to CLEAR with index 1 on the next edge; writes presented in that same cycle SHALL still commit.
REQ-017 clr_req SHALL be ignored while in CLEAR.
REQ-018 A write port SHALL commit WDx to entry Ax on the rising edge when WEx=1, state=READY, Ax!=0 and Ax<NREGS; otherwise that port SHALL have no effect.
REQ-019 If A3==A4 and both ports qualify for a write, port 0 (WE3/WD3) SHALL win and port 1's write SHALL be dropped.
REQ-020 Reads SHALL be combinational; RDn=0 when An==0 or An>=NREGS.
REQ-021 With BYPASS=1, RDn SHALL return WD3 when port 0 qualifies for a write to An, else WD4 when port 1 qualifies for a write to An, else the stored value.
REQ-022 With BYPASS=0, RDn SHALL return the stored value only; a write becomes visible in the cycle after it commits.
REQ-023 x0 SHALL read 0 at all times and SHALL never be stored or forwarded.

Reset
REQ-024 reset=1 at a rising edge SHALL force the state to CLEAR with index 1 and busy=1 from that edge, overriding clr_req and both write ports.
REQ-025 reset asserted mid-clear SHALL restart the sequence at index 1.
REQ-026 After reset deasserts, busy SHALL stay 1 for exactly NREGS-1 cycles; all entries read 0 once busy=0.
REQ-027 The storage array SHALL not rely on initial blocks; zeroing is performed only by the CLEAR sequence.

Structure
REQ-028 The shared package SHALL hold: REG_ADDR_W=5, the state enum {CLEAR, READY}, and the XLEN default.
REQ-029 One sub-module, regfile_rdport, SHALL implement a single read port (zero/range check plus bypass mux) and be instantiated twice.
REQ-030 Storage SHALL be a flat array of NREGS-1 entries of XLEN bits, with no entry for x0.

Verification
REQ-031 Reset, NREGS=32: reset for 1 cycle -> busy=1 for 31 cycles; then RD1 for A1=5 returns 0.
REQ-032 READY, BYPASS=1: WE3=1, A3=7, WD3=0xDEADBEEF with A1=7 -> RD1=0xDEADBEEF in the same cycle and stays so next cycle with WE3=0.
REQ-033 Write collision: A3=A4=9, WD3=0x11, WD4=0x22 -> the next cycle reads x9=0x11.
REQ-034 x0 and range, NREGS=16: write 0x55 to A3=0 and to A3=20 -> A1=0 and A1=20 both read 0; no stored entry changes.
REQ-035 Clear under writes: x3=0xAB, then clr_req=1 -> busy for NREGS-1 cycles; a WE4 write during busy is ignored; x3 reads 0 afterwards.
REQ-036 BYPASS=0: write 0x77 to x4 while A2=4 -> RD2 shows the old value that cycle and 0x77 the next.
